// File: rtl/alu_ser_pkg.sv
// alu_ser_pkg
// Shared types and constants for the ALU result serializer.
//   - state_t       : frame FSM states (IDLE, SEND, DONE)
//   - DATA_W_DEF    : default result width
//   - FLAG_W_DEF    : default flag width
//   - MAX_BITS_DEF  : longest possible frame (data + flags + parity slot)
//   - BCNT_W_DEF    : bit counter width for the default widths
//   - CYC_W         : cycle counter width, wide enough for BIT_CYCLES up to 255
package alu_ser_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int FLAG_W_DEF   = 4;
    localparam int MAX_BITS_DEF = DATA_W_DEF + FLAG_W_DEF + 1;
    localparam int BCNT_W_DEF   = $clog2(DATA_W_DEF + FLAG_W_DEF + 2);
    localparam int CYC_W        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_result_serializer_if.sv
// alu_result_serializer_if
// Bundles the request and serial-output signals of the serializer.
//   master : drives start/with_flags/result_in/flags_in, observes the outputs
//   slave  : the serializer itself
// Signals:
//   start, with_flags, result_in[DATA_W], flags_in[FLAG_W]  (master -> slave)
//   ser_out, bit_tick, frame, busy, done                    (slave -> master)
interface alu_result_serializer_if
    import alu_ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FLAG_W = FLAG_W_DEF
);
    logic              start;
    logic              with_flags;
    logic [DATA_W-1:0] result_in;
    logic [FLAG_W-1:0] flags_in;
    logic              ser_out;
    logic              bit_tick;
    logic              frame;
    logic              busy;
    logic              done;

    modport master (
        output start, with_flags, result_in, flags_in,
        input  ser_out, bit_tick, frame, busy, done
    );

    modport slave (
        input  start, with_flags, result_in, flags_in,
        output ser_out, bit_tick, frame, busy, done
    );
endinterface

// File: rtl/alu_ser_bit_timer.sv
// alu_ser_bit_timer
// Divides the clock into bit periods of BIT_CYCLES cycles while run is high.
// Ports:
//   clk      : clock
//   reset    : synchronous active-high reset
//   run      : counting enable; counter is held at 0 while low
//   bit_tick : high in the last cycle of each bit period
module alu_ser_bit_timer
    import alu_ser_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic bit_tick
);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(BIT_CYCLES - 1);

    logic [CYC_W-1:0] cyc_reg;

    // Combinational so the strobe lines up with the cycle the counter reaches LAST_CYC;
    // with BIT_CYCLES=1 this is simply run.
    assign bit_tick = run && (cyc_reg == LAST_CYC);

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_reg <= '0;
        end else if (!run || bit_tick) begin
            cyc_reg <= '0;
        end else begin
            cyc_reg <= cyc_reg + 1'b1;
        end
    end
endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer
// Bit-serial transmitter for ALU results. On an accepted start the result (and
// optionally the flags) is captured and shifted out, each bit held for
// BIT_CYCLES cycles, with a bit_tick strobe in the last cycle of every period.
// Optional build macro ALU_SER_PARITY_EN appends an even-parity bit.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (aborts any frame, no done pulse)
//   bus   : alu_result_serializer_if.slave (start, with_flags, result_in,
//           flags_in in; ser_out, bit_tick, frame, busy, done out)
module alu_result_serializer
    import alu_ser_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FLAG_W     = FLAG_W_DEF,
    parameter int BIT_CYCLES = 4,
    parameter int LSB_FIRST  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    alu_result_serializer_if.slave  bus
);
    localparam int MB = DATA_W + FLAG_W + 1;
    localparam int BW = $clog2(DATA_W + FLAG_W + 2);
`ifdef ALU_SER_PARITY_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif
    localparam logic [BW-1:0] N_DATA  = BW'(DATA_W + EXTRA);
    localparam logic [BW-1:0] N_FLAGS = BW'(DATA_W + FLAG_W + EXTRA);

    state_t          state_reg, state_next;
    logic [MB-1:0]   sreg_reg;
    logic [MB-1:0]   load_val;
    logic [BW-1:0]   bit_cnt_reg;
    logic [BW-1:0]   nbits_reg;
    logic            tick;
    logic            cur_bit;
    logic            last_bit;
    logic            ser_out_next, frame_next, busy_next, done_next;
`ifdef ALU_SER_PARITY_EN
    logic            par;
`endif

    alu_ser_bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (state_reg == SEND),
        .bit_tick (tick)
    );

    // Pack the payload so the first bit to send sits at the shift-out end:
    // bit 0 for LSB-first (shift right), bit MB-1 for MSB-first (shift left).
    always_comb begin
        load_val = '0;
`ifdef ALU_SER_PARITY_EN
        par = (^bus.result_in) ^ (bus.with_flags & (^bus.flags_in));
`endif
        if (LSB_FIRST != 0) begin
            load_val[DATA_W-1:0] = bus.result_in;
            if (bus.with_flags) begin
                load_val[DATA_W +: FLAG_W] = bus.flags_in;
`ifdef ALU_SER_PARITY_EN
                load_val[DATA_W + FLAG_W] = par;
`endif
            end else begin
`ifdef ALU_SER_PARITY_EN
                load_val[DATA_W] = par;
`endif
            end
        end else begin
            load_val[MB-1 -: DATA_W] = bus.result_in;
            if (bus.with_flags) begin
                load_val[MB-1-DATA_W -: FLAG_W] = bus.flags_in;
`ifdef ALU_SER_PARITY_EN
                load_val[0] = par;
`endif
            end else begin
`ifdef ALU_SER_PARITY_EN
                load_val[MB-1-DATA_W] = par;
`endif
            end
        end
    end

    assign cur_bit  = (LSB_FIRST != 0) ? sreg_reg[0] : sreg_reg[MB-1];
    assign last_bit = (bit_cnt_reg == (nbits_reg - 1'b1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ser_out_next = 1'b0;
        frame_next   = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                frame_next   = 1'b1;
                busy_next    = 1'b1;
                ser_out_next = cur_bit;
                if (tick && last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy_next  = 1'b1;
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register and bit counter; start is only looked at in IDLE, so
    // requests during SEND/DONE are dropped rather than queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_reg    <= '0;
            bit_cnt_reg <= '0;
            nbits_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        sreg_reg    <= load_val;
                        bit_cnt_reg <= '0;
                        nbits_reg   <= bus.with_flags ? N_FLAGS : N_DATA;
                    end
                end
                SEND: begin
                    if (tick) begin
                        sreg_reg    <= (LSB_FIRST != 0) ? (sreg_reg >> 1) : (sreg_reg << 1);
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    bit_cnt_reg <= '0;
                end
            endcase
        end
    end

    assign bus.ser_out  = ser_out_next;
    assign bus.bit_tick = tick;
    assign bus.frame    = frame_next;
    assign bus.busy     = busy_next;
    assign bus.done     = done_next;
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer
// Two serializer instances: A (BIT_CYCLES=4, LSB first) and B (BIT_CYCLES=1,
// MSB first). Expected serial bits are queued when a frame is requested and
// popped on every bit_tick; frame timing is checked cycle by cycle.
module tb_alu_result_serializer;
`ifdef ALU_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk;
    logic reset;

    alu_result_serializer_if #(.DATA_W(8), .FLAG_W(4)) if_a ();
    alu_result_serializer_if #(.DATA_W(8), .FLAG_W(4)) if_b ();

    alu_result_serializer #(.DATA_W(8), .FLAG_W(4), .BIT_CYCLES(4), .LSB_FIRST(1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    alu_result_serializer #(.DATA_W(8), .FLAG_W(4), .BIT_CYCLES(1), .LSB_FIRST(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic exp_q[$];
    bit   sel = 1'b0;   // 0 = observe A, 1 = observe B

    logic m_ser, m_tick, m_frame, m_busy, m_done;
    always_comb begin
        m_ser   = sel ? if_b.ser_out  : if_a.ser_out;
        m_tick  = sel ? if_b.bit_tick : if_a.bit_tick;
        m_frame = sel ? if_b.frame    : if_a.frame;
        m_busy  = sel ? if_b.busy     : if_a.busy;
        m_done  = sel ? if_b.done     : if_a.done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic st, input logic wf,
                         input logic [7:0] r, input logic [3:0] f);
        if (s) begin
            if_b.start = st; if_b.with_flags = wf; if_b.result_in = r; if_b.flags_in = f;
        end else begin
            if_a.start = st; if_a.with_flags = wf; if_a.result_in = r; if_a.flags_in = f;
        end
    endtask

    task automatic push_expected(input bit lsb, input logic [7:0] r,
                                 input logic [3:0] f, input logic wf);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(lsb ? r[i] : r[7-i]);
            p = p ^ r[i];
        end
        if (wf) begin
            for (int i = 0; i < 4; i++) begin
                exp_q.push_back(lsb ? f[i] : f[3-i]);
                p = p ^ f[i];
            end
        end
        if (PAR != 0) exp_q.push_back(p);
    endtask

    // Scoreboard: every bit_tick consumes one expected bit.
    always @(negedge clk) begin
        if (!reset && m_tick) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tick", 32'(m_tick), 32'd0);
            end else begin
                check("ser_bit", 32'(m_ser), 32'(exp_q.pop_front()));
            end
        end
    end

    // Requests one frame and checks every cycle through the return to IDLE.
    // inject_k > 0 pulses start (result 0xFF) during that SEND cycle.
    task automatic run_frame(input bit s, input int bc, input bit lsb,
                             input logic [7:0] r, input logic [3:0] f,
                             input logic wf, input int inject_k);
        int n;
        int len;
        n   = 8 + (wf ? 4 : 0) + PAR;
        len = n * bc;
        sel = s;
        drive(s, 1'b1, wf, r, f);
        push_expected(lsb, r, f, wf);
        step();
        // Scramble inputs after capture; the frame must not change.
        drive(s, 1'b0, ~wf, ~r, ~f);
        for (int k = 1; k <= len + 2; k++) begin
            if (k > 1) step();
            if (inject_k > 0 && k == inject_k) drive(s, 1'b1, 1'b0, 8'hFF, 4'hF);
            if (inject_k > 0 && k == inject_k + 1) drive(s, 1'b0, ~wf, ~r, ~f);
            check($sformatf("tick_c%0d", k),  32'(m_tick),  32'((k <= len) && (k % bc == 0)));
            check($sformatf("frame_c%0d", k), 32'(m_frame), 32'(k <= len));
            check($sformatf("busy_c%0d", k),  32'(m_busy),  32'(k <= len + 1));
            check($sformatf("done_c%0d", k),  32'(m_done),  32'(k == len + 1));
            if (k > len) check($sformatf("ser_idle_c%0d", k), 32'(m_ser), 32'd0);
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int guard;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
        repeat (3) step();
        check("rst_a_busy",  32'(if_a.busy),  32'd0);
        check("rst_a_frame", 32'(if_a.frame), 32'd0);
        check("rst_a_ser",   32'(if_a.ser_out), 32'd0);
        check("rst_b_busy",  32'(if_b.busy),  32'd0);
        check("rst_b_done",  32'(if_b.done),  32'd0);
        reset = 1'b0;
        step();

        // Data only, LSB first, 4 cycles per bit.
        run_frame(1'b0, 4, 1'b1, 8'hA5, 4'h0, 1'b0, 0);
        step();
        // Data and flags, MSB first, 1 cycle per bit.
        run_frame(1'b1, 1, 1'b0, 8'h3C, 4'h9, 1'b1, 0);
        step();
        // Start pulse mid-frame is ignored.
        run_frame(1'b0, 4, 1'b1, 8'hA5, 4'h0, 1'b0, 10);
        step();
        // Parity-relevant patterns (plain frames in the default build).
        run_frame(1'b0, 4, 1'b1, 8'h07, 4'h0, 1'b0, 0);
        step();
        run_frame(1'b0, 4, 1'b1, 8'hA5, 4'h3, 1'b1, 0);
        step();
        run_frame(1'b1, 1, 1'b0, 8'h81, 4'h6, 1'b0, 0);
        step();

        // Reset at the third bit_tick of a frame.
        sel = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 8'hA5, 4'h0);
        push_expected(1'b1, 8'hA5, 4'h0, 1'b0);
        step();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        ticks = 0;
        guard = 0;
        while (ticks < 3 && guard < 200) begin
            if (if_a.bit_tick) ticks++;
            if (ticks < 3) begin
                step();
                guard++;
            end
        end
        check("rst_reach_tick3", 32'(ticks), 32'd3);
        reset = 1'b1;
        step();
        check("midrst_ser",   32'(if_a.ser_out),  32'd0);
        check("midrst_tick",  32'(if_a.bit_tick), 32'd0);
        check("midrst_frame", 32'(if_a.frame),    32'd0);
        check("midrst_busy",  32'(if_a.busy),     32'd0);
        check("midrst_done",  32'(if_a.done),     32'd0);
        exp_q.delete();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("postrst_done_%0d", k), 32'(if_a.done), 32'd0);
            check($sformatf("postrst_busy_%0d", k), 32'(if_a.busy), 32'd0);
        end
        run_frame(1'b0, 4, 1'b1, 8'h5A, 4'h0, 1'b0, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
